mult_datapath: RTL and testbench
================================

// Module: mult_datapath
// PURPOSE
// - Register/arithmetic datapath for the 8-bit signed add-shift multiplier.
// - Sits directly downstream of the multiplier control FSM and executes its 3-bit op code each cycle.
// - Holds X (sign extension), A (upper product) and B (multiplier/lower product); returns M = B[0] to the FSM.
// - Gates ADD/SUB/SHIFT with its own run window and shift counter, so idle "shift" codes from the FSM never corrupt a result.
// PARAMETERS
// - W  8  operand width; A, B, Sw width; adder is W+1 bits.
// PORTS
// - Clk      in   1  system clock; all state changes on rising edge.
// - Reset_n  in   1  synchronous, active-low reset.
// - Op       in   3  op code from control FSM: 000 LOAD, 001 SHIFT, 010 ADD, 011 SUB, 100 CLEAR_XA; 101-111 hold.
// - Run      in   1  start request, level; only its rising edge is used.
// - Sw       in   W  switch operand: the multiplier on LOAD, the multiplicand S on ADD/SUB.
// - Aval     out  W  A register.
// - Bval     out  W  B register.
// - X        out  1  X register.
// - M        out  1  B[0], combinational from register.
// - Busy     out  1  run window open; ADD/SUB/SHIFT take effect only while Busy=1.
// - Done     out  1  8 shifts completed since last LOAD/CLEAR_XA.
// BEHAVIOUR
// - Reset (Reset_n=0 at edge): A=0, B=0, X=0, Busy=0, Done=0, cnt=0, run_q=0. Reset overrides everything.
// - run_q <= Run every cycle. start = Run & ~run_q & ~Busy & ~Done.
// - Priority per edge: Reset > LOAD/CLEAR_XA > start > gated op.
// - LOAD: B<=Sw, A<=0, X<=0, cnt<=0, Busy<=0, Done<=0.
//   - Aborts a run in progress.
//   - A start edge in the same cycle is dropped.
// - CLEAR_XA: A<=0, X<=0, cnt<=0, Busy<=0, Done<=0; B unchanged.
// - start: Busy<=1 next edge. Any op presented in the start cycle itself is ignored, because Busy is still 0.
// - ADD (Busy=1): {X,A} <= {A[W-1],A} + {Sw[W-1],Sw}, W+1-bit two's complement; carry out discarded.
// - SUB (Busy=1): {X,A} <= {A[W-1],A} + ~{Sw[W-1],Sw} + 1.
// - SHIFT (Busy=1, cnt<W): arithmetic right shift of X:A:B.
//   - X unchanged, A<={X,A[W-1:1]}, B<={A[0],B[W-1:1]}, cnt<=cnt+1.
//   - On the W-th shift (cnt==W-1): Busy<=0, Done<=1 on the same edge.
// - When Busy=0, ADD, SUB, SHIFT and the 101-111 codes hold all registers.
// - Done stays 1 until LOAD or CLEAR_XA.
// - A Run held high across CLEAR_XA does not restart the run; a new rising edge is required.
// - Latency: every op result is visible on outputs one cycle after the edge; M follows B with no extra delay.
// - cnt is ceil(log2(W+1)) bits and never exceeds W.
// STRUCTURE
// - Shared package mult_pkg:
//   - Op-code localparams/enum (OP_LOAD, OP_SHIFT, OP_ADD, OP_SUB, OP_CLR_XA), so the FSM and datapath share encodings.
//   - Default W.
// - One sub-module, add_sub_unit (W+1-bit ripple adder with subtract input inverting B and forcing carry-in 1).
// - Registers, counter, run-edge detect and gating stay in mult_datapath.
// TESTING
// - Reset: Reset_n=0 for 1 cycle from random state -> A=00, B=00, X=0, Busy=0, Done=0, M=0.
// - LOAD Sw=0x07 -> B=07, A=00, X=0, M=1. SHIFT with Busy=0 -> all registers unchanged.
// - Arithmetic after Run edge:
//   - ADD Sw=0x05 from A=00 -> A=05, X=0.
//   - Then SUB Sw=0x0A -> A=FB, X=1.
// - Full multiply, FSM op sequence driven by bench: LOAD Sw=0xFD, Run edge, Sw=0x07
//   -> after 8 shifts {A,B}=FFEB (-21), X=1, Done=1, Busy=0.
// - Shift limit: 10 SHIFTs while run active -> only 8 applied, Done rises on the 8th edge, later shifts hold.
// - Abort: LOAD Sw=0x22 after 3 shifts -> Busy=0, Done=0, cnt=0, B=22. Run held high through CLEAR_XA -> Busy stays 0.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg
// Purpose : Shared definitions for the 8-bit signed add-shift multiplier.
//           The control FSM and the datapath both import this package, so the
//           op-code encodings and the default operand width live in one place.
// Contents: MULT_W_DEFAULT - default operand width
//           op_e           - 3-bit op codes issued by the FSM each cycle
//           cnt_width()    - width of a counter that must hold 0..w
package mult_pkg;

  localparam int MULT_W_DEFAULT = 8;

  // Codes 101-111 are not named; the datapath treats them as "hold".
  typedef enum logic [2:0] {
    OP_LOAD   = 3'b000,
    OP_SHIFT  = 3'b001,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_CLR_XA = 3'b100
  } op_e;

  // The shift counter has to reach the value w itself, hence w+1 states.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : mult_pkg

// File: rtl/add_sub_unit.sv
// add_sub_unit
// Purpose : (W+1)-bit ripple-carry adder/subtractor used by the multiplier
//           datapath to form {X,A} +/- {S_sign,S}.
// Ports   : i_a   in  W+1  first operand (sign-extended A)
//           i_b   in  W+1  second operand (sign-extended switch value)
//           i_sub in  1    1 = subtract (i_a - i_b), 0 = add
//           o_sum out W+1  two's complement result, carry out discarded
module add_sub_unit
  import mult_pkg::*;
#(
  parameter int W = MULT_W_DEFAULT
) (
  input  logic [W:0] i_a,
  input  logic [W:0] i_b,
  input  logic       i_sub,
  output logic [W:0] o_sum
);

  logic [W:0] w_b_op;
  logic [W:0] w_carry;

  // Subtraction is a + ~b + 1: invert b and feed the 1 in as carry-in.
  assign w_b_op     = i_b ^ {(W + 1){i_sub}};
  assign w_carry[0] = i_sub;

  genvar g;
  generate
    for (g = 0; g <= W; g++) begin : g_bit
      assign o_sum[g] = i_a[g] ^ w_b_op[g] ^ w_carry[g];
      // The carry out of the top bit is never needed, so the chain stops there.
      if (g < W) begin : g_carry
        assign w_carry[g + 1] = (i_a[g] & w_b_op[g]) |
                                (i_a[g] & w_carry[g]) |
                                (w_b_op[g] & w_carry[g]);
      end
    end
  endgenerate

endmodule : add_sub_unit

// File: rtl/mult_datapath.sv
// mult_datapath
// Purpose : Register/arithmetic datapath of the 8-bit signed add-shift
//           multiplier. Executes the FSM op code every cycle on the X, A and B
//           registers. ADD/SUB/SHIFT are only honoured inside a run window
//           opened by a Run rising edge and closed after W shifts, so idle
//           shift codes from the FSM cannot disturb a finished product.
// Ports   : Clk     in  1  system clock, rising edge
//           Reset_n in  1  synchronous active-low reset
//           Op      in  3  op code (LOAD/SHIFT/ADD/SUB/CLEAR_XA, others hold)
//           Run     in  1  start request, only its rising edge matters
//           Sw      in  W  multiplier on LOAD, multiplicand on ADD/SUB
//           Aval    out W  A register (upper product)
//           Bval    out W  B register (multiplier / lower product)
//           X       out 1  sign-extension register
//           M       out 1  B[0], fed back to the FSM
//           Busy    out 1  run window open
//           Done    out 1  W shifts completed since last LOAD/CLEAR_XA
module mult_datapath
  import mult_pkg::*;
#(
  parameter int W = MULT_W_DEFAULT
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [2:0]   Op,
  input  logic         Run,
  input  logic [W-1:0] Sw,
  output logic [W-1:0] Aval,
  output logic [W-1:0] Bval,
  output logic         X,
  output logic         M,
  output logic         Busy,
  output logic         Done
);

  localparam int CW = cnt_width(W);

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_x;
  logic         r_busy;
  logic         r_done;
  logic         r_run_q;
  logic [CW-1:0] r_cnt;

  logic         w_start;
  logic         w_sub;
  logic [W:0]   w_sum;

  // A start needs a fresh Run edge and an idle, not-yet-finished datapath;
  // after Done the FSM must LOAD or CLEAR_XA before another run can begin.
  assign w_start = Run & ~r_run_q & ~r_busy & ~r_done;
  assign w_sub   = (Op == OP_SUB);

  add_sub_unit #(.W(W)) u_add_sub (
    .i_a   ({r_a[W-1], r_a}),
    .i_b   ({Sw[W-1], Sw}),
    .i_sub (w_sub),
    .o_sum (w_sum)
  );

  // Main register update. Priority: reset, then LOAD/CLEAR_XA (which abort a
  // run and swallow a coincident start), then start, then the gated ops. The
  // op presented in the start cycle is ignored since Busy is still 0 there.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_run_q <= 1'b0;
    end else begin
      r_run_q <= Run;
      if (Op == OP_LOAD) begin
        r_b    <= Sw;
        r_a    <= '0;
        r_x    <= 1'b0;
        r_cnt  <= '0;
        r_busy <= 1'b0;
        r_done <= 1'b0;
      end else if (Op == OP_CLR_XA) begin
        r_a    <= '0;
        r_x    <= 1'b0;
        r_cnt  <= '0;
        r_busy <= 1'b0;
        r_done <= 1'b0;
      end else if (w_start) begin
        r_busy <= 1'b1;
      end else if (r_busy) begin
        case (Op)
          OP_ADD, OP_SUB: begin
            {r_x, r_a} <= w_sum;
          end
          OP_SHIFT: begin
            if (r_cnt < CW'(W)) begin
              r_a   <= {r_x, r_a[W-1:1]};
              r_b   <= {r_a[0], r_b[W-1:1]};
              r_cnt <= r_cnt + 1'b1;
              // The W-th shift closes the window and flags completion together.
              if (r_cnt == CW'(W - 1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign X    = r_x;
  assign M    = r_b[0];
  assign Busy = r_busy;
  assign Done = r_done;

endmodule : mult_datapath

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath
// Purpose : Self-checking bench for mult_datapath. A table of single-cycle
//           vectors covers load, gating and basic arithmetic; hand-written
//           sequences cover the full multiply, shift limit, abort and
//           CLEAR_XA-with-Run-held cases.
module tb_mult_datapath;
  import mult_pkg::*;

  localparam int W = 8;

  logic         Clk;
  logic         Reset_n;
  logic [2:0]   Op;
  logic         Run;
  logic [W-1:0] Sw;
  logic [W-1:0] Aval;
  logic [W-1:0] Bval;
  logic         X;
  logic         M;
  logic         Busy;
  logic         Done;

  int total;
  int bad;

  mult_datapath #(.W(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Op      (Op),
    .Run     (Run),
    .Sw      (Sw),
    .Aval    (Aval),
    .Bval    (Bval),
    .X       (X),
    .M       (M),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic       run;
    logic [7:0] sw;
    logic [7:0] a;
    logic [7:0] b;
    logic       x;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[10];

  // Drive one cycle of inputs, clock once, then sample 1 time unit later.
  task automatic applyStimulus(input logic [2:0] op, input logic run, input logic [7:0] sw);
    Op  = op;
    Run = run;
    Sw  = sw;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic x, input logic busy, input logic done);
    total++;
    if (Aval !== a || Bval !== b || X !== x || M !== b[0] || Busy !== busy || Done !== done) begin
      bad++;
      $display("[TB] FAIL %s: got A=%h B=%h X=%b M=%b Busy=%b Done=%b, want A=%h B=%h X=%b M=%b Busy=%b Done=%b",
               name, Aval, Bval, X, M, Busy, Done, a, b, x, b[0], busy, done);
    end
  endtask

  initial begin
    logic [15:0] prod;
    logic [7:0]  mbits;
    total   = 0;
    bad     = 0;
    Reset_n = 1'b0;
    Op      = 3'b111;
    Run     = 1'b0;
    Sw      = '0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // Scramble state, then reset from there.
    applyStimulus(OP_LOAD, 1'b0, 8'($urandom));
    applyStimulus(3'b101, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++)
      applyStimulus(3'($urandom_range(1, 3)), 1'b1, 8'($urandom));
    Reset_n = 1'b0;
    applyStimulus(OP_ADD, 1'b1, 8'h33);
    Reset_n = 1'b1;
    checkOutput("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    vecs[0] = '{"load07",       OP_LOAD,   1'b0, 8'h07, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"shift_idle",   OP_SHIFT,  1'b0, 8'h00, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"start",        3'b101,    1'b1, 8'h00, 8'h00, 8'h07, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"add05",        OP_ADD,    1'b1, 8'h05, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"sub0A",        OP_SUB,    1'b1, 8'h0A, 8'hFB, 8'h07, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{"hold110",      3'b110,    1'b1, 8'h55, 8'hFB, 8'h07, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{"clrxa",        OP_CLR_XA, 1'b1, 8'h55, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"shift_runhi",  OP_SHIFT,  1'b1, 8'h00, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{"add_idle",     OP_ADD,    1'b0, 8'h05, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{"start_opign",  OP_ADD,    1'b1, 8'h05, 8'h00, 8'h07, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].run, vecs[i].sw);
      checkOutput(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].x, vecs[i].busy, vecs[i].done);
    end

    // Full multiply: -3 * 7, the FSM sequence for multiplier bits of 0xFD.
    applyStimulus(OP_LOAD, 1'b0, 8'hFD);
    applyStimulus(3'b111, 1'b1, 8'h07);
    checkOutput("mul_start", 8'h00, 8'hFD, 1'b0, 1'b1, 1'b0);
    mbits = 8'hFD;
    for (int i = 0; i < 8; i++) begin
      if (mbits[i])
        applyStimulus((i == 7) ? OP_SUB : OP_ADD, 1'b1, 8'h07);
      applyStimulus(OP_SHIFT, 1'b1, 8'h07);
    end
    checkOutput("mul_result", 8'hFF, 8'hEB, 1'b1, 1'b0, 1'b1);
    applyStimulus(OP_SHIFT, 1'b0, 8'h07);
    checkOutput("mul_hold", 8'hFF, 8'hEB, 1'b1, 1'b0, 1'b1);

    // Shift limit: A=10, B=81, X=0 -> ten shifts, only eight applied.
    applyStimulus(OP_LOAD, 1'b0, 8'h81);
    applyStimulus(3'b101, 1'b1, 8'h00);
    applyStimulus(OP_ADD, 1'b1, 8'h10);
    checkOutput("lim_add", 8'h10, 8'h81, 1'b0, 1'b1, 1'b0);
    prod = 16'h1081;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(OP_SHIFT, 1'b1, 8'h00);
      if (k <= 8) prod = prod >> 1;
      checkOutput($sformatf("lim_shift%0d", k), prod[15:8], prod[7:0], 1'b0,
                  (k < 8) ? 1'b1 : 1'b0, (k >= 8) ? 1'b1 : 1'b0);
    end

    // Abort: three shifts into a run, then LOAD 0x22 with Run still high.
    applyStimulus(OP_LOAD, 1'b0, 8'h40);
    applyStimulus(3'b101, 1'b1, 8'h00);
    for (int k = 0; k < 3; k++) applyStimulus(OP_SHIFT, 1'b1, 8'h00);
    checkOutput("abort_pre", 8'h00, 8'h08, 1'b0, 1'b1, 1'b0);
    applyStimulus(OP_LOAD, 1'b1, 8'h22);
    checkOutput("abort_load", 8'h00, 8'h22, 1'b0, 1'b0, 1'b0);
    // Counter must restart: eight fresh shifts are needed again.
    applyStimulus(3'b101, 1'b0, 8'h00);
    applyStimulus(3'b101, 1'b1, 8'h00);
    for (int k = 0; k < 7; k++) applyStimulus(OP_SHIFT, 1'b1, 8'h00);
    checkOutput("abort_cnt7", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(OP_SHIFT, 1'b1, 8'h00);
    checkOutput("abort_cnt8", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // CLEAR_XA with Run held high must not restart.
    applyStimulus(OP_CLR_XA, 1'b1, 8'h00);
    checkOutput("clr_runhi", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_ADD, 1'b1, 8'h09);
    checkOutput("clr_noreStart", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // LOAD in the same cycle as a Run edge drops the start.
    applyStimulus(3'b101, 1'b0, 8'h00);
    applyStimulus(OP_LOAD, 1'b1, 8'h5A);
    applyStimulus(OP_ADD, 1'b1, 8'h01);
    checkOutput("load_drops_start", 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mult_datapath
